// File: rtl/led_pwm_bank.sv
// N-channel LED driver behind an Avalon-MM register file.
// Each channel is OFF, ON, PWM-dimmed or BLINK, all clocked from one shared prescaler tick.
`timescale 1ns/1ps
module led_pwm_bank #(
  parameter int NUM_CH        = 4,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 16,
  parameter int ADDR_W        = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   avs_address,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  input  logic                avs_read,
  output logic [31:0]         avs_readdata,
  output logic                avs_readdatavalid,
  output logic [NUM_CH-1:0]   led_out
);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_PWM   = 2'b10;
  localparam logic [1:0] MODE_BLINK = 2'b11;

  logic                     enable_r;
  logic                     invert_r;
  logic [PRESCALE_BITS-1:0] prescale_r;
  logic [PRESCALE_BITS-1:0] pcnt_r;
  logic [PWM_BITS-1:0]      pwm_cnt_r;
  logic [1:0]               mode_r        [NUM_CH];
  logic [PWM_BITS-1:0]      duty_shadow_r [NUM_CH];
  logic [PWM_BITS-1:0]      duty_active_r [NUM_CH];
  logic [PWM_BITS-1:0]      bcnt_r        [NUM_CH];
  logic [NUM_CH-1:0]        blink_r;

  logic                     wr_ctrl_s;
  logic                     wr_presc_s;
  logic [NUM_CH-1:0]        wr_mode_s;
  logic [NUM_CH-1:0]        wr_duty_s;
  logic                     tick_s;
  logic                     wrap_s;
  logic [NUM_CH-1:0]        raw_s;
  logic [31:0]              rd_ch_s;
  logic [31:0]              rd_data_s;
  logic                     unused_wdata_s;

  assign unused_wdata_s = ^avs_writedata;

  // Write-strobe decode and shared tick/wrap qualifiers
  always_comb begin
    wr_ctrl_s  = avs_write && (avs_address == ADDR_W'(0));
    wr_presc_s = avs_write && (avs_address == ADDR_W'(1));
    wr_mode_s  = '0;
    wr_duty_s  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_mode_s[c] = avs_write && (avs_address == ADDR_W'(4 + 2 * c));
      wr_duty_s[c] = avs_write && (avs_address == ADDR_W'(5 + 2 * c));
    end
    tick_s = enable_r && (pcnt_r == prescale_r);
    wrap_s = tick_s && (pwm_cnt_r == {PWM_BITS{1'b1}});
  end

  // Per-channel raw drive before enable masking and inversion
  always_comb begin
    raw_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      case (mode_r[c])
        MODE_OFF:   raw_s[c] = 1'b0;
        MODE_ON:    raw_s[c] = 1'b1;
        MODE_PWM:   raw_s[c] = (pwm_cnt_r < duty_active_r[c]);
        MODE_BLINK: raw_s[c] = blink_r[c];
        default:    raw_s[c] = 1'b0;
      endcase
    end
  end

  // Read mux; returns pre-write values when a write to the same word coincides
  always_comb begin
    rd_ch_s = 32'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      rd_ch_s = rd_ch_s
              | ((avs_address == ADDR_W'(4 + 2 * c)) ? 32'(mode_r[c])        : 32'd0)
              | ((avs_address == ADDR_W'(5 + 2 * c)) ? 32'(duty_shadow_r[c]) : 32'd0);
    end
    if (avs_address == ADDR_W'(0)) begin
      rd_data_s = {30'd0, invert_r, enable_r};
    end else if (avs_address == ADDR_W'(1)) begin
      rd_data_s = 32'(prescale_r);
    end else if (avs_address == ADDR_W'(2)) begin
      rd_data_s = 32'(led_out);
    end else begin
      rd_data_s = rd_ch_s;
    end
  end

  // Software-visible configuration registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_r   <= 1'b0;
      invert_r   <= 1'b0;
      prescale_r <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        mode_r[c]        <= MODE_OFF;
        duty_shadow_r[c] <= '0;
      end
    end else begin
      if (wr_ctrl_s) begin
        enable_r <= avs_writedata[0];
        invert_r <= avs_writedata[1];
      end
      if (wr_presc_s) begin
        prescale_r <= avs_writedata[PRESCALE_BITS-1:0];
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_mode_s[c]) begin
          mode_r[c] <= avs_writedata[1:0];
        end
        if (wr_duty_s[c]) begin
          duty_shadow_r[c] <= avs_writedata[PWM_BITS-1:0];
        end
      end
    end
  end

  // Shared prescaler and PWM counter; held at zero while disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_r    <= '0;
      pwm_cnt_r <= '0;
    end else if (!enable_r) begin
      pcnt_r    <= '0;
      pwm_cnt_r <= '0;
    end else begin
      if (wr_presc_s || tick_s) begin
        pcnt_r <= '0;
      end else begin
        pcnt_r <= pcnt_r + PRESCALE_BITS'(1);
      end
      if (tick_s) begin
        pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
      end
    end
  end

  // Active duty only reloads at the PWM wrap so a period is never cut short
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_r <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        duty_active_r[c] <= '0;
        bcnt_r[c]        <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!enable_r) begin
          duty_active_r[c] <= wr_duty_s[c] ? avs_writedata[PWM_BITS-1:0] : duty_shadow_r[c];
          bcnt_r[c]        <= '0;
          blink_r[c]       <= 1'b0;
        end else begin
          if (wrap_s) begin
            duty_active_r[c] <= duty_shadow_r[c];
          end
          if (wr_mode_s[c]) begin
            bcnt_r[c]  <= '0;
            blink_r[c] <= 1'b0;
          end else if (tick_s) begin
            if (bcnt_r[c] == duty_shadow_r[c]) begin
              bcnt_r[c]  <= '0;
              blink_r[c] <= ~blink_r[c];
            end else begin
              bcnt_r[c] <= bcnt_r[c] + PWM_BITS'(1);
            end
          end
        end
      end
    end
  end

  // Registered LED drive and fixed-latency read response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out           <= '0;
      avs_readdatavalid <= 1'b0;
      avs_readdata      <= 32'd0;
    end else begin
      led_out           <= (enable_r ? raw_s : '0) ^ {NUM_CH{invert_r}};
      avs_readdatavalid <= avs_read;
      avs_readdata      <= avs_read ? rd_data_s : 32'd0;
    end
  end

endmodule
